// File: rtl/music_tempo_gen.sv
// Tempo clock generator: divides sys_clk into a square wave with a per-mode half-period,
// switching divisors only at half-period boundaries, and emits beat/bar strobes.
module music_tempo_gen #(
  parameter int CNT_W         = 26,
  parameter int DIV_SLOW      = 12500000,
  parameter int DIV_MID       = 6250000,
  parameter int DIV_FAST      = 3125000,
  parameter int BEATS_PER_BAR = 4,
  parameter int BEAT_W        = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              en,
  input  logic [2:0]        sel,
  input  logic [CNT_W-1:0]  cfg_half,
  output logic              clk_select,
  output logic              beat_tick,
  output logic              bar_tick,
  output logic [BEAT_W-1:0] beat_cnt
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_BAR - 1);
  localparam logic [CNT_W-1:0]  ONE       = CNT_W'(1);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] active_half;

  // A zero terminal count is clamped to 1 so a half-period never drops below 2 cycles.
  function automatic logic [CNT_W-1:0] decode(input logic [2:0] s, input logic [CNT_W-1:0] c);
    logic [CNT_W-1:0] d;
    case (s)
      3'b100:  d = CNT_W'(DIV_FAST);
      3'b001:  d = CNT_W'(DIV_MID);
      3'b111:  d = c;
      default: d = CNT_W'(DIV_SLOW);
    endcase
    if (d == '0) d = ONE;
    return d;
  endfunction

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      count       <= '0;
      clk_select  <= 1'b0;
      beat_tick   <= 1'b0;
      bar_tick    <= 1'b0;
      beat_cnt    <= '0;
      active_half <= decode(sel, cfg_half);
    end else begin
      beat_tick <= 1'b0;
      bar_tick  <= 1'b0;
      if (en) begin
        // Using >= lets any over-range count terminate on the next enabled edge.
        if (count >= active_half) begin
          count       <= '0;
          clk_select  <= ~clk_select;
          active_half <= decode(sel, cfg_half);
          if (!clk_select) begin
            beat_tick <= 1'b1;
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              bar_tick <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end
          end
        end else begin
          count <= count + ONE;
        end
      end
    end
  end

endmodule
